// File: rtl/vdp_pkg.sv
// Shared VDP definitions: command mode encodings, register indices, VRAM geometry.
package vdp_pkg;

  localparam int unsigned VRAM_ADDR_W = 15;

  typedef enum logic [1:0] {
    MODE_REG_SELECT = 2'b00,
    MODE_REG_WRITE  = 2'b01,
    MODE_DATA       = 2'b10,
    MODE_RESERVED   = 2'b11
  } cmd_mode_e;

  localparam logic [7:0] REG_WADDR_LO = 8'h00;
  localparam logic [7:0] REG_WADDR_HI = 8'h01;
  localparam logic [7:0] REG_WSTEP    = 8'h02;

endpackage

// File: rtl/vdp_write_queue_if.sv
// Host command channel plus VRAM write port of the VDP write queue.
interface vdp_write_queue_if
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W
);

  logic              cmd_valid;
  logic [1:0]        cmd_mode;
  logic [7:0]        cmd_data;
  logic              cmd_ready;
  logic [7:0]        status;
  logic              vram_req;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              vram_grant;

  modport master (
    output cmd_valid, cmd_mode, cmd_data, vram_grant,
    input  cmd_ready, status, vram_req, vram_addr, vram_wdata
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_data, vram_grant,
    output cmd_ready, status, vram_req, vram_addr, vram_wdata
  );

endinterface

// File: rtl/vdp_sync_fifo.sv
// Synchronous FIFO with registered count and a head that is readable without popping.
module vdp_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/vdp_write_queue.sv
// VDP command front end: decodes host commands into auto-incrementing VRAM writes and queues them.
// Optional build macro VDP_WQ_AUTOINC_STEP_EN makes the increment step programmable via reg 0x02.
module vdp_write_queue
  import vdp_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = VRAM_ADDR_W
) (
  input logic              clk,
  input logic              reset,
  vdp_write_queue_if.slave bus
);

  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned FifoW = ADDR_W + 8;

  cmd_mode_e         w_mode;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CntW-1:0]   w_count;
  logic [FifoW-1:0]  w_head;
  logic [4:0]        w_cnt_ext;
  logic [3:0]        w_cnt_sat;
  logic [7:0]        w_step;
  logic [7:0]        r_reg_select;
  logic [ADDR_W-1:0] r_waddr;

  assign w_mode        = cmd_mode_e'(bus.cmd_mode);
  assign bus.cmd_ready = (w_mode == MODE_DATA) ? !w_full : 1'b1;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  assign w_push        = w_accept && (w_mode == MODE_DATA);
  assign w_pop         = bus.vram_req && bus.vram_grant;

`ifdef VDP_WQ_AUTOINC_STEP_EN
  logic [7:0] r_step;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_step <= 8'h01;
    end else if (w_accept && (w_mode == MODE_REG_WRITE) && (r_reg_select == REG_WSTEP)) begin
      r_step <= bus.cmd_data;
    end
  end

  assign w_step = r_step;
`else
  assign w_step = 8'h01;
`endif

  // High address register covers bits [ADDR_W-1:8]; surplus payload bits are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg_select <= 8'h00;
      r_waddr      <= '0;
    end else if (w_accept) begin
      case (w_mode)
        MODE_REG_SELECT: r_reg_select <= bus.cmd_data;
        MODE_REG_WRITE: begin
          if (r_reg_select == REG_WADDR_LO) begin
            r_waddr[7:0] <= bus.cmd_data;
          end else if (r_reg_select == REG_WADDR_HI) begin
            r_waddr[ADDR_W-1:8] <= bus.cmd_data[ADDR_W-9:0];
          end
        end
        MODE_DATA: r_waddr <= r_waddr + ADDR_W'(w_step);
        default: ;
      endcase
    end
  end

  vdp_sync_fifo #(
    .WIDTH (FifoW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata ({r_waddr, bus.cmd_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Head is masked while empty so the port reads zero instead of stale storage.
  assign bus.vram_req   = !w_empty;
  assign bus.vram_addr  = w_empty ? '0 : w_head[FifoW-1:8];
  assign bus.vram_wdata = w_empty ? '0 : w_head[7:0];

  assign w_cnt_ext  = 5'(w_count);
  assign w_cnt_sat  = (w_cnt_ext > 5'd15) ? 4'hF : w_cnt_ext[3:0];
  assign bus.status = {w_cnt_sat, 2'b00, w_empty, w_full};

endmodule

// File: tb/tb_vdp_write_queue.sv
// Directed bench for vdp_write_queue; a negedge monitor records every VRAM write for comparison.
module tb_vdp_write_queue;
  import vdp_pkg::*;

  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [22:0] wr_q[$];

  always #5 clk = ~clk;

  vdp_write_queue_if #(.ADDR_W(VRAM_ADDR_W)) bus ();

  vdp_write_queue #(
    .DEPTH  (Depth),
    .ADDR_W (VRAM_ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Inputs change #1 after posedge, so negedge values are what the next posedge sees.
  always @(negedge clk) begin
    if (reset && bus.vram_req && bus.vram_grant) wr_q.push_back({bus.vram_addr, bus.vram_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] m, input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    bus.cmd_data  = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic set_addr(input logic [14:0] a);
    do_cmd(MODE_REG_SELECT, REG_WADDR_LO);
    do_cmd(MODE_REG_WRITE, a[7:0]);
    do_cmd(MODE_REG_SELECT, REG_WADDR_HI);
    do_cmd(MODE_REG_WRITE, {1'b1, a[14:8]});
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_mode   = 2'b00;
    bus.cmd_data   = 8'h00;
    bus.vram_grant = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("rst_status", 32'(bus.status), 32'h02);
    chk("rst_req", 32'(bus.vram_req), 32'h0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_addr", 32'(bus.vram_addr), 32'h0);
    chk("rst_wdata", 32'(bus.vram_wdata), 32'h0);

    // Basic writes with grant held; a reserved command in the middle changes nothing.
    bus.vram_grant = 1'b1;
    set_addr(15'h1234);
    do_cmd(MODE_DATA, 8'hAA);
    do_cmd(MODE_DATA, 8'hBB);
    do_cmd(MODE_RESERVED, 8'hFF);
    do_cmd(MODE_DATA, 8'hCC);
    repeat (3) tick();
    chk("basic_n", 32'(wr_q.size()), 32'd3);
    chk("basic_0", 32'(wr_q[0]), 32'({15'h1234, 8'hAA}));
    chk("basic_1", 32'(wr_q[1]), 32'({15'h1235, 8'hBB}));
    chk("basic_2", 32'(wr_q[2]), 32'({15'h1236, 8'hCC}));
    chk("basic_status", 32'(bus.status), 32'h02);

    // Address wrap, with head held stable while grant is low.
    bus.vram_grant = 1'b0;
    wr_q.delete();
    set_addr(15'h7FFF);
    do_cmd(MODE_DATA, 8'h51);
    do_cmd(MODE_DATA, 8'h52);
    chk("wrap_req", 32'(bus.vram_req), 32'h1);
    chk("wrap_status", 32'(bus.status), 32'h20);
    tick();
    chk("wrap_head_addr", 32'(bus.vram_addr), 32'h7FFF);
    chk("wrap_head_data", 32'(bus.vram_wdata), 32'h51);
    bus.vram_grant = 1'b1;
    repeat (3) tick();
    bus.vram_grant = 1'b0;
    chk("wrap_n", 32'(wr_q.size()), 32'd2);
    chk("wrap_0", 32'(wr_q[0]), 32'({15'h7FFF, 8'h51}));
    chk("wrap_1", 32'(wr_q[1]), 32'({15'h0000, 8'h52}));

    // Fill to full, then one grant frees a slot for the held ninth write.
    wr_q.delete();
    set_addr(15'h0000);
    for (int i = 0; i < 8; i++) do_cmd(MODE_DATA, 8'(8'h10 + i));
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = MODE_DATA;
    bus.cmd_data  = 8'h99;
    #1;
    chk("full_ready", 32'(bus.cmd_ready), 32'h0);
    chk("full_status", 32'(bus.status), 32'h81);
    bus.cmd_mode = MODE_REG_SELECT;
    #1;
    chk("full_ready_sel", 32'(bus.cmd_ready), 32'h1);
    bus.cmd_mode   = MODE_DATA;
    bus.vram_grant = 1'b1;
    tick();
    bus.vram_grant = 1'b0;
    chk("pop_ready", 32'(bus.cmd_ready), 32'h1);
    chk("pop_status", 32'(bus.status), 32'h70);
    chk("pop_n", 32'(wr_q.size()), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("refill_status", 32'(bus.status), 32'h81);
    bus.vram_grant = 1'b1;
    repeat (10) tick();
    bus.vram_grant = 1'b0;
    chk("fill_n", 32'(wr_q.size()), 32'd9);
    chk("fill_first", 32'(wr_q[0]), 32'({15'h0000, 8'h10}));
    chk("fill_last", 32'(wr_q[8]), 32'({15'h0008, 8'h99}));

    // Programmable step (ignored without the feature macro).
    wr_q.delete();
    bus.vram_grant = 1'b1;
    set_addr(15'h0100);
    do_cmd(MODE_REG_SELECT, REG_WSTEP);
    do_cmd(MODE_REG_WRITE, 8'h20);
    for (int i = 0; i < 3; i++) do_cmd(MODE_DATA, 8'(8'hE0 + i));
    repeat (3) tick();
    chk("step_n", 32'(wr_q.size()), 32'd3);
`ifdef VDP_WQ_AUTOINC_STEP_EN
    chk("step_0", 32'(wr_q[0]), 32'({15'h0100, 8'hE0}));
    chk("step_1", 32'(wr_q[1]), 32'({15'h0120, 8'hE1}));
    chk("step_2", 32'(wr_q[2]), 32'({15'h0140, 8'hE2}));
`else
    chk("step_0", 32'(wr_q[0]), 32'({15'h0100, 8'hE0}));
    chk("step_1", 32'(wr_q[1]), 32'({15'h0101, 8'hE1}));
    chk("step_2", 32'(wr_q[2]), 32'({15'h0102, 8'hE2}));
`endif

    // Reset mid-drain discards the queue and restores address and step.
    bus.vram_grant = 1'b0;
    wr_q.delete();
    set_addr(15'h0200);
    for (int i = 0; i < 4; i++) do_cmd(MODE_DATA, 8'(8'h30 + i));
    chk("mid_status", 32'(bus.status), 32'h40);
    bus.vram_grant = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_req", 32'(bus.vram_req), 32'h0);
    chk("mid_rst_status", 32'(bus.status), 32'h02);
    reset = 1'b1;
    repeat (5) tick();
    chk("mid_rst_n", 32'(wr_q.size()), 32'd1);
    chk("mid_rst_0", 32'(wr_q[0]), 32'({15'h0200, 8'h30}));
    wr_q.delete();
    do_cmd(MODE_DATA, 8'h77);
    do_cmd(MODE_DATA, 8'h88);
    repeat (3) tick();
    chk("post_rst_n", 32'(wr_q.size()), 32'd2);
    chk("post_rst_0", 32'(wr_q[0]), 32'({15'h0000, 8'h77}));
    chk("post_rst_1", 32'(wr_q[1]), 32'({15'h0001, 8'h88}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vdp_write_queue.md
# vdp_write_queue

Command-side front end of the VDP. Decodes single-cycle host commands (register select, register write, data write) into a VRAM write address with auto-increment. Buffers each data write as an {address, byte} entry in a small FIFO. Drains the FIFO into the VRAM write port whenever the display arbiter grants a slot. It sits between the host strobe edge-detector and the VRAM port, so host writes never stall on display fetches until the FIFO fills.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16
- ADDR_W, 15, VRAM address width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  command present this cycle
- cmd_mode  in  2  00 register select, 01 register write, 10 data write, 11 reserved
- cmd_data  in  8  command payload
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- status  out  8  bit0 full, bit1 empty, bits3:2 zero, bits7:4 entry count (saturated at 15)
- vram_req  out  1  FIFO head valid
- vram_addr  out  ADDR_W  head entry address
- vram_wdata  out  8  head entry data
- vram_grant  in  1  VRAM write performed this cycle when vram_req && vram_grant

## Operation
- Registers: reg_select (8b); reg 0x00 = write address [7:0]; reg 0x01 = write address [14:8] (cmd_data[7] ignored); reg 0x02 = increment step (8b, zero-extended).
- Mode 00: reg_select <= cmd_data.
- Mode 01: write the selected register; unknown indices ignored.
- Mode 10: push {write_addr, cmd_data}; write_addr <= (write_addr + step) mod 2^ADDR_W (0x7FFF + 1 wraps to 0x0000).
- Mode 11: accepted and ignored; no state change.
- cmd_ready = 1 for modes 00/01/11; for mode 10 it equals ~full. Combinational from cmd_mode and registered count.
- Register writes take effect for the next accepted data write. Entries already queued keep their captured address.
- Drain: vram_req = ~empty. vram_addr/vram_wdata show the head entry and stay stable while vram_req && ~vram_grant. On a grant, the head pops.
- Simultaneous push and pop: allowed when not full; count unchanged. When full, no push occurs that cycle, so a pop frees space and cmd_ready rises on the next cycle (no bypass).

## Timing
- Reset values: write_addr 0x0000, step 0x01, reg_select 0x00, FIFO empty, vram_req 0, vram_addr 0, vram_wdata 0, status 0x02, cmd_ready 1.
- Reset mid-operation: all queued entries are discarded. vram_req is 0 in the cycle after reset is sampled low.
- Latency: a data write accepted at edge N makes the entry visible at the head (vram_req=1) after edge N, at the earliest. The address register updates at the same edge.
- Pop: a grant sampled at edge M presents the next entry (or vram_req=0) after edge M.
- status is registered and updates one edge after any push or pop.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- VDP_WQ_AUTOINC_STEP_EN defined: reg 0x02 is writable and sets the increment step; step 0 means the address stays fixed.
- Not defined: step is hard-wired to 1, and writes to reg 0x02 are ignored like any unknown index.

## Structure
- Shared package vdp_pkg holds:
  - mode encodings MODE_REG_SELECT, MODE_REG_WRITE, MODE_DATA, MODE_RESERVED
  - register indices REG_WADDR_LO, REG_WADDR_HI, REG_WSTEP
  - VRAM_ADDR_W = 15
- One sub-module, vdp_sync_fifo: parameterised width/depth, registered count, full/empty flags, head read without a pop cycle.
- Command decode and address arithmetic live in vdp_write_queue itself.

## Test plan
- Reset low for 2 cycles, then high -> status 0x02, vram_req 0, cmd_ready 1.
- Select 0x00 and write 0x34, select 0x01 and write 0x12, then 3 data writes AA/BB/CC with grant held high -> VRAM writes (0x1234,AA), (0x1235,BB), (0x1236,CC) in order.
- Address 0x7FFF, step 1, two data writes -> entries at 0x7FFF and 0x0000.
- Grant held low, DEPTH=8, 9 data writes -> cmd_ready 0 after the 8th push, status 0x81. One grant -> the 9th write is accepted the following cycle.
- With VDP_WQ_AUTOINC_STEP_EN, step set to 0x20 from address 0x0100, 3 writes -> 0x0100, 0x0120, 0x0140. Without the macro, the same stimulus -> 0x0100, 0x0101, 0x0102.
- 4 entries queued and reset asserted mid-drain -> vram_req 0 the next cycle, status 0x02, and no further VRAM writes.
